// File: rtl/demux_deserializer.sv
// Serial-to-parallel steering: each accepted bit lands in O[sel], LSB first.
// Define DESER_PARITY_EN to append an even-parity beat per frame (par_err).
module demux_deserializer #(
   parameter int OWIDTH = 37,
   parameter int SWIDTH = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_bit,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [OWIDTH-1:0] O,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SWIDTH-1:0] sel,
   output logic              par_err
);

`ifdef DESER_PARITY_EN
   localparam logic [SWIDTH-1:0] LAST = SWIDTH'(OWIDTH);
`else
   localparam logic [SWIDTH-1:0] LAST = SWIDTH'(OWIDTH - 1);
`endif

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [SWIDTH-1:0]   sel_q;
   logic [OWIDTH-1:0]   o_q;
   logic                beat;
   logic                last_beat;

   assign beat      = in_ready & in_valid;
   assign last_beat = beat & (sel_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         COLLECT: if (last_beat) state_d = HOLD;
         HOLD:    if (out_ready) state_d = COLLECT;
         default: state_d = COLLECT;
      endcase
   end

   // Handshake outputs come from registered state only.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         COLLECT: in_ready  = 1'b1;
         HOLD:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q <= '0;
      end else if (last_beat) begin
         sel_q <= '0;
      end else if (beat) begin
         sel_q <= sel_q + SWIDTH'(1);
      end
   end

   // Bits overwrite in place; the parity slot (sel==OWIDTH) matches no k.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q <= '0;
      end else begin
         for (int k = 0; k < OWIDTH; k++) begin
            if (beat && (sel_q == SWIDTH'(k))) begin
               o_q[k] <= in_bit;
            end
         end
      end
   end

`ifdef DESER_PARITY_EN
   logic par_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else if (last_beat) begin
         par_q <= (^o_q) ^ in_bit;
      end else if (beat && (sel_q == '0)) begin
         par_q <= 1'b0;
      end
   end

   assign par_err = par_q;
`else
   assign par_err = 1'b0;
`endif

   assign O   = o_q;
   assign sel = sel_q;

endmodule

// File: tb/tb_demux_deserializer.sv
// Directed bench for demux_deserializer: vector table plus corner sequences.
// Works with or without DESER_PARITY_EN defined.
module tb_demux_deserializer;

   localparam int OW = 37;
   localparam int SW = 6;
`ifdef DESER_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FB = OW + (PAR ? 1 : 0);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_bit = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [OW-1:0] O;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [SW-1:0] sel;
   logic          par_err;

   demux_deserializer #(.OWIDTH(OW), .SWIDTH(SW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bit    (in_bit),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .O         (O),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel       (sel),
      .par_err   (par_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OW-1:0] frame;
      logic          p;
      bit            gap;
      logic          exp_par;
   } vec_t;

   vec_t          vecs[5];
   int            n_pass = 0;
   int            n_tot = 0;
   int            stalls;
   logic [OW-1:0] cap[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic logic [127:0] mk_seq(input logic [OW-1:0] f,
                                           input logic p);
      logic [127:0] s;
      s = '0;
      s[OW-1:0] = f;
      if (PAR) s[OW] = p;
      return s;
   endfunction

   // Offers seq[0..n-1] honouring in_ready; samples outputs on negedges.
   task automatic send(input logic [127:0] seq, input int n, input bit gap);
      int   i;
      int   cyc;
      logic acc;
      i = 0;
      cyc = 0;
      while (i < n && cyc < 4 * n + 20) begin
         in_valid = 1'b1;
         in_bit   = seq[i];
         acc      = in_ready;
         @(negedge clk);
         cyc++;
         if (out_valid) cap.push_back(O);
         if (acc) begin
            i++;
            if (gap) begin
               in_valid = 1'b0;
               in_bit   = ~in_bit;
               @(negedge clk);
               cyc++;
               if (out_valid) cap.push_back(O);
            end
         end else begin
            stalls++;
         end
      end
      in_valid = 1'b0;
      if (i < n) chk("send_timeout", 64'(i), 64'(n));
   endtask

   task automatic release_hold(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_rel_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [127:0] s;
      logic [OW-1:0] fa;
      logic [OW-1:0] fb;

      vecs[0] = '{37'h10_000F_57CE, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{37'h0A_AAAA_AAAA, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{37'h10_000F_57CE, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{37'h00_0000_0000, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{37'h15_5555_5555, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_O", 64'(O), 64'd0);
      chk("rst_sel", 64'(sel), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_par_err", 64'(par_err), 64'd0);

      for (int v = 0; v < 5; v++) begin
         s = mk_seq(vecs[v].frame, vecs[v].p);
         send(s, FB - 1, vecs[v].gap);
         chk($sformatf("v%0d_pre_last_valid", v), 64'(out_valid), 64'd0);
         send(s >> (FB - 1), 1, vecs[v].gap);
         chk($sformatf("v%0d_O", v), 64'(O), 64'(vecs[v].frame));
         chk($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d_in_ready", v), 64'(in_ready), 64'd0);
         chk($sformatf("v%0d_sel", v), 64'(sel), 64'd0);
         chk($sformatf("v%0d_par_err", v), 64'(par_err),
             64'(PAR ? vecs[v].exp_par : 1'b0));
         in_valid = 1'b1;
         for (int c = 0; c < 20; c++) begin
            in_bit = c[0];
            @(negedge clk);
         end
         in_valid = 1'b0;
         chk($sformatf("v%0d_hold_O", v), 64'(O), 64'(vecs[v].frame));
         chk($sformatf("v%0d_hold_sel", v), 64'(sel), 64'd0);
         chk($sformatf("v%0d_hold_valid", v), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d_hold_par", v), 64'(par_err),
             64'(PAR ? vecs[v].exp_par : 1'b0));
         release_hold($sformatf("v%0d", v));
      end

      // Reset mid-frame discards the partial word immediately.
      send(mk_seq(37'h1F_FFFF_FFFF, 1'b1), 10, 1'b0);
      chk("mid_sel_10", 64'(sel), 64'd10);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_O", 64'(O), 64'd0);
      chk("mid_rst_sel", 64'(sel), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(mk_seq(37'h1F_FFFF_FFFF, 1'b1), FB, 1'b0);
      chk("ones_O", 64'(O), 64'h1F_FFFF_FFFF);
      chk("ones_par_err", 64'(par_err), 64'd0);
      release_hold("ones");

      // Back-to-back frames with a consumer that is always ready.
      fa = 37'h15_5555_5555;
      fb = 37'h0F_0F0F_0F0F;
      s = mk_seq(fb, 1'b0);
      s = s << FB;
      s = s | mk_seq(fa, 1'b1);
      cap.delete();
      stalls = 0;
      out_ready = 1'b1;
      send(s, 2 * FB, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      chk("b2b_stalls", 64'(stalls), 64'd1);
      chk("b2b_frames", 64'(cap.size()), 64'd2);
      if (cap.size() >= 2) begin
         chk("b2b_O_a", 64'(cap[0]), 64'(fa));
         chk("b2b_O_b", 64'(cap[1]), 64'(fb));
      end
      chk("b2b_idle_valid", 64'(out_valid), 64'd0);
      chk("b2b_idle_ready", 64'(in_ready), 64'd1);

`ifdef DESER_PARITY_EN
      send(mk_seq(37'h10_000F_57CE, 1'b0), FB, 1'b0);
      chk("par_bad", 64'(par_err), 64'd1);
      release_hold("par");
      chk("par_kept_collect", 64'(par_err), 64'd1);
      send(mk_seq(37'h1, 1'b1), 1, 1'b0);
      chk("par_cleared", 64'(par_err), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
